// File: rtl/ps2_pkg.sv
// Shared scancode constants, the prefix-FSM state encoding and byte classifiers
// used by the PS/2 key decoder.
package ps2_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  // Controller/status bytes that never form a key event
  localparam logic [7:0] SC_ERR0  = 8'h00;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_ACK   = 8'hFA;
  localparam logic [7:0] SC_RESND = 8'hFE;
  localparam logic [7:0] SC_ECHO  = 8'hEE;
  localparam logic [7:0] SC_ERR1  = 8'hFF;

  // Arrow keys; these codes are arrows only behind an E0 prefix
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  // Event packing: {ext, break, code}
  localparam int EV_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  // True for bytes that are dropped and reset the prefix state
  function automatic logic is_discard(input logic [7:0] b);
    logic hit;
    case (b)
      SC_ERR0, SC_BAT, SC_ACK, SC_RESND, SC_ECHO, SC_ERR1: hit = 1'b1;
      default:                                             hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO for decoded key events. Full + pop + push in one cycle
// is accepted; a push into a full FIFO without pop is dropped and latched
// in a sticky overflow flag.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW:0]      count_r;
  logic             overflow_r;
  logic             do_pop_s;
  logic             do_push_s;

  // Decide which requests take effect this cycle
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    if (pop && (count_r != '0)) begin
      do_pop_s = 1'b1;
    end else begin
      do_pop_s = 1'b0;
    end
    if (push && ((count_r != FULL_COUNT) || do_pop_s)) begin
      do_push_s = 1'b1;
    end else begin
      do_push_s = 1'b0;
    end
  end

  // Storage write; contents need no reset because the head is masked when empty
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
      if (push && !do_push_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign head_valid = (count_r != '0);
  assign head_data  = head_valid ? mem_r[rd_ptr_r] : '0;
  assign count      = count_r;
  assign overflow   = overflow_r;

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns raw PS/2 set-2 scancode bytes into {code, ext, break} events queued
// in a FIFO, and tracks the held state of the four extended arrow keys.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_valid,
  input  logic [7:0]             key_byte,
  input  logic                   pop,
  output logic                   ev_valid,
  output logic [7:0]             ev_code,
  output logic                   ev_ext,
  output logic                   ev_break,
  output logic [$clog2(DEPTH):0] ev_count,
  output logic                   overflow,
  output logic                   arrow_left,
  output logic                   arrow_right,
  output logic                   arrow_up,
  output logic                   arrow_down
);

  ps2_state_e          state_r;
  ps2_state_e          next_state_s;
  logic                emit_s;
  logic                emit_ext_s;
  logic                emit_brk_s;
  logic [EV_WIDTH-1:0] head_s;

  // Prefix state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Prefix decoding and event emission
  always_comb begin
    next_state_s = state_r;
    emit_s       = 1'b0;
    emit_ext_s   = 1'b0;
    emit_brk_s   = 1'b0;
    if (key_valid) begin
      if (key_byte == SC_EXT) begin
        next_state_s = ST_EXT;
      end else if (key_byte == SC_BREAK) begin
        case (state_r)
          ST_IDLE: next_state_s = ST_BRK;
          ST_EXT:  next_state_s = ST_EXT_BRK;
          default: next_state_s = state_r;
        endcase
      end else if (is_discard(key_byte)) begin
        next_state_s = ST_IDLE;
      end else begin
        next_state_s = ST_IDLE;
        emit_s       = 1'b1;
        emit_ext_s   = (state_r == ST_EXT) || (state_r == ST_EXT_BRK);
        emit_brk_s   = (state_r == ST_BRK) || (state_r == ST_EXT_BRK);
      end
    end else begin
      next_state_s = state_r;
    end
  end

  // Arrow key held state, driven by extended events even if the FIFO drops them
  always_ff @(posedge clk) begin
    if (reset) begin
      arrow_left  <= 1'b0;
      arrow_right <= 1'b0;
      arrow_up    <= 1'b0;
      arrow_down  <= 1'b0;
    end else if (emit_s && emit_ext_s) begin
      case (key_byte)
        SC_LEFT:  arrow_left  <= !emit_brk_s;
        SC_RIGHT: arrow_right <= !emit_brk_s;
        SC_UP:    arrow_up    <= !emit_brk_s;
        SC_DOWN:  arrow_down  <= !emit_brk_s;
        default:  arrow_left  <= arrow_left;
      endcase
    end
  end

  ps2_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EV_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (emit_s),
    .wdata      ({emit_ext_s, emit_brk_s, key_byte}),
    .pop        (pop),
    .head_valid (ev_valid),
    .head_data  (head_s),
    .count      (ev_count),
    .overflow   (overflow)
  );

  assign ev_ext   = head_s[9];
  assign ev_break = head_s[8];
  assign ev_code  = head_s[7:0];

endmodule
